// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter
//
// Merges the Ibex instruction-fetch port and the LSU data port onto one
// shared host port. All three ports use the req/gnt/rvalid protocol.
// Arbitration is round-robin. A request that is waiting for grant keeps the
// host port locked to the same requester, so address and control stay stable.
// A small FIFO records which requester owns each granted transaction, so that
// in-order responses can be steered back to the correct requester.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   instr_*              instruction-fetch requester (read-only)
//   data_*               LSU requester (read/write, byte enables)
//   host_*               shared memory/bus host port
//   unexp_rvalid_o       sticky flag: a response arrived with nothing outstanding
//
// Parameters:
//   MaxOutstanding       maximum number of granted-but-unanswered transactions (1..8)

module ibex_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        host_req_o,
  input  logic        host_gnt_i,
  input  logic        host_rvalid_i,
  output logic        host_we_o,
  output logic [3:0]  host_be_o,
  output logic [31:0] host_addr_o,
  output logic [31:0] host_wdata_o,
  input  logic [31:0] host_rdata_i,
  input  logic        host_err_i,

  output logic        unexp_rvalid_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic {
    SrcInstr = 1'b0,
    SrcData  = 1'b1
  } src_e;

  src_e            fifo_q [MaxOutstanding];
  src_e            fifo_d [MaxOutstanding];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            lock_q, lock_d;
  src_e            locked_sel_q, locked_sel_d;
  src_e            last_winner_q, last_winner_d;
  logic            unexp_q, unexp_d;

  logic            full;
  logic            fifo_empty;
  src_e            sel;
  src_e            head;
  logic            push;
  logic            pop;

  // Full uses only the registered count, so a response in the same cycle
  // does not free a slot until the following cycle.
  assign full       = (count_q == CntW'(MaxOutstanding));
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_q[rptr_q];

  always_comb begin
    sel = SrcInstr;
    if (lock_q) begin
      sel = locked_sel_q;
    end else if (instr_req_i && data_req_i) begin
      // On a tie, the requester that did not win last time gets the port.
      sel = (last_winner_q == SrcInstr) ? SrcData : SrcInstr;
    end else if (data_req_i) begin
      sel = SrcData;
    end
  end

  assign host_req_o   = (instr_req_i | data_req_i) & ~full;
  assign host_addr_o  = (sel == SrcData) ? data_addr_i : instr_addr_i;
  assign host_we_o    = (sel == SrcData) ? data_we_i : 1'b0;
  assign host_be_o    = (sel == SrcData) ? data_be_i : 4'b1111;
  assign host_wdata_o = (sel == SrcData) ? data_wdata_i : 32'h0;

  assign push        = host_req_o & host_gnt_i;
  assign instr_gnt_o = push & (sel == SrcInstr);
  assign data_gnt_o  = push & (sel == SrcData);

  // A response with nothing outstanding is dropped and not forwarded to either requester.
  assign pop            = host_rvalid_i & ~fifo_empty;
  assign instr_rvalid_o = pop & (head == SrcInstr);
  assign data_rvalid_o  = pop & (head == SrcData);

  assign instr_rdata_o  = host_rdata_i;
  assign data_rdata_o   = host_rdata_i;
  assign instr_err_o    = host_err_i;
  assign data_err_o     = host_err_i;
  assign unexp_rvalid_o = unexp_q;

  always_comb begin
    fifo_d        = fifo_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    count_d       = count_q;
    lock_d        = lock_q;
    locked_sel_d  = locked_sel_q;
    last_winner_d = last_winner_q;
    unexp_d       = unexp_q | (host_rvalid_i & fifo_empty);

    if (push) begin
      fifo_d[wptr_q] = sel;
      wptr_d         = (wptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wptr_q + PtrW'(1);
      last_winner_d  = sel;
    end
    if (pop) begin
      rptr_d = (rptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rptr_q + PtrW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // Freeze the selection while the host stalls, so the host sees a stable
    // request until it grants.
    if (host_req_o && !host_gnt_i) begin
      lock_d       = 1'b1;
      locked_sel_d = sel;
    end else if (host_gnt_i) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MaxOutstanding); i++) begin
        fifo_q[i] <= SrcInstr;
      end
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      lock_q        <= 1'b0;
      locked_sel_q  <= SrcInstr;
      last_winner_q <= SrcInstr;
      unexp_q       <= 1'b0;
    end else begin
      fifo_q        <= fifo_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      lock_q        <= lock_d;
      locked_sel_q  <= locked_sel_d;
      last_winner_q <= last_winner_d;
      unexp_q       <= unexp_d;
    end
  end

`ifdef IBEX_MEM_ARB_ASSERT
  unexp_rvalid_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    host_rvalid_i |-> !fifo_empty);
`endif

endmodule
